// File: rtl/gate_sweep_pkg.sv
// Shared types and sizing helpers for the gate sweep sequencer.
package gate_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DONE   = 2'd2
  } state_e;

  // Number of input vectors for an n-input gate.
  function automatic int n_vec(input int n);
    return 2 ** n;
  endfunction

  // Width of the settle counter; it only has to reach settle-1, but never narrower than 1 bit.
  function automatic int cnt_w(input int settle);
    return (settle <= 1) ? 1 : $clog2(settle);
  endfunction

endpackage

// File: rtl/first_mismatch_enc.sv
// Lowest-set-bit priority encoder over a mismatch vector.
module first_mismatch_enc #(
  parameter int W  = 4,
  parameter int IW = 2
) (
  input  logic [W-1:0]  diff_i,
  output logic          any_mismatch_o,
  output logic [IW-1:0] idx_o
);

  // Scan from the top down so the lowest mismatching position is the one left in idx_o.
  always_comb begin
    // NOTE: every output gets a default before any conditional write, so no latch is inferred.
    any_mismatch_o = |diff_i;
    idx_o          = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (diff_i[i]) idx_o = IW'(i);
    end
  end

endmodule

// File: rtl/gate_sweep_ctrl.sv
// Sweeps an N_IN-input gate through all vectors, captures its truth table and
// compares it with an expected table latched when the sweep starts.
module gate_sweep_ctrl
  import gate_sweep_pkg::*;
#(
  parameter int N_IN       = 2,
  parameter int SETTLE_CYC = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [2**N_IN-1:0]    expected,
  output logic [N_IN-1:0]       gate_in,
  input  logic                  gate_out,
  output logic                  busy,
  output logic                  done,
  output logic [2**N_IN-1:0]    truth_table,
  output logic                  pass,
  output logic [N_IN-1:0]       fail_idx
);

  localparam int NV = n_vec(N_IN);
  localparam int CW = cnt_w(SETTLE_CYC);
  localparam logic [N_IN-1:0] LAST_VEC = N_IN'(NV - 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(SETTLE_CYC - 1);

  state_e            state_q, state_d;
  logic [N_IN-1:0]   vec_q, vec_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [NV-1:0]     table_q, table_d;
  logic [NV-1:0]     exp_q, exp_d;
  logic              pass_q, pass_d;
  logic [N_IN-1:0]   fidx_q, fidx_d;

  logic              go;
  logic              sample;
  logic [NV-1:0]     table_sampled;
  logic              any_mm;
  logic [N_IN-1:0]   mm_idx;

  // An abort in the same cycle as start keeps the block idle; an abort in SETTLE suppresses the sample.
  assign go     = (state_q == IDLE) && start && !abort;
  assign sample = (state_q == SETTLE) && !abort && (cnt_q == CNT_LAST);

  // Table as it will look after this cycle's sample, so the final verdict includes the last vector.
  always_comb begin
    table_sampled         = table_q;
    table_sampled[vec_q]  = gate_out;
  end

  first_mismatch_enc #(
    .W  (NV),
    .IW (N_IN)
  ) u_enc (
    .diff_i         (table_sampled ^ exp_q),
    .any_mismatch_o (any_mm),
    .idx_o          (mm_idx)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (go) state_d = SETTLE;
      SETTLE:  if (abort) state_d = IDLE;
               else if (sample && (vec_q == LAST_VEC)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode: busy only while settling, done for the single DONE cycle.
  always_comb begin
    busy = (state_q == SETTLE);
    done = (state_q == DONE);
  end

  // Datapath next-state: vector/settle counters, capture, and verdict on the last sample.
  always_comb begin
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    table_d = table_q;
    exp_d   = exp_q;
    pass_d  = pass_q;
    fidx_d  = fidx_q;
    if (go) begin
      exp_d   = expected;
      vec_d   = '0;
      cnt_d   = '0;
      table_d = '0;
    end else if (state_q == SETTLE) begin
      if (abort) begin
        vec_d = '0;
        cnt_d = '0;
      end else if (sample) begin
        table_d = table_sampled;
        cnt_d   = '0;
        if (vec_q != LAST_VEC) begin
          vec_d = vec_q + 1'b1;
        end else begin
          pass_d = ~any_mm;
          fidx_d = mm_idx;
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vec_q   <= '0;
      cnt_q   <= '0;
      table_q <= '0;
      exp_q   <= '0;
      pass_q  <= 1'b0;
      fidx_q  <= '0;
    end else begin
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      table_q <= table_d;
      exp_q   <= exp_d;
      pass_q  <= pass_d;
      fidx_q  <= fidx_d;
    end
  end

  assign gate_in     = vec_q;
  assign truth_table = table_q;
  assign pass        = pass_q;
  assign fail_idx    = fidx_q;

endmodule
